// File: rtl/serial_cmp_pkg.sv
// rtl/serial_cmp_pkg.sv - shared types and sizing helpers for the serial magnitude comparator
//
// Purpose: FSM state encoding, default operand/digit widths and the helper
//          functions that derive the step count and step-counter width.
// Ports:   none (package).

package serial_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIGIT = 4;

  // Number of digit steps needed to walk the whole operand.
  function automatic int calc_nstep(input int width, input int digit);
    return width / digit;
  endfunction

  // Counter is sized to hold NSTEP itself, not just NSTEP-1.
  function automatic int calc_cnt_width(input int width, input int digit);
    return $clog2((width / digit) + 1);
  endfunction

endpackage

// File: rtl/digit_compare.sv
// rtl/digit_compare.sv - combinational unsigned compare of one digit
//
// Purpose: flags whether digit x is greater than or less than digit y.
// Ports:   x, y : DIGIT-bit unsigned digits
//          gt   : x > y
//          lt   : x < y

module digit_compare #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  output logic             gt,
  output logic             lt
);

  assign gt = (x > y);
  assign lt = (x < y);

endmodule

// File: rtl/serial_magnitude_compare.sv
// rtl/serial_magnitude_compare.sv - digit-serial unsigned magnitude comparator
//
// Purpose: compares two unsigned WIDTH-bit operands one DIGIT-bit digit per
//          clock, most significant digit first. The first differing digit
//          decides the result through sticky gt/lt flags.
// Optional: EARLY_EXIT_EN - finish in the cycle the first differing digit is
//          seen instead of always walking all NSTEP digits.
// Ports:   clk   : rising-edge clock
//          rst_n : asynchronous active-low reset
//          start : request, sampled only while ready
//          a, b  : operands, captured on the accepted start edge
//          ready : high in IDLE
//          busy  : high in CMP
//          done  : one-cycle result-valid pulse
//          gt/lt/eq : registered result, held until the next accepted start

module serial_magnitude_compare
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  localparam int NSTEP = calc_nstep(WIDTH, DIGIT);
  localparam int CW    = calc_cnt_width(WIDTH, DIGIT);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             s_gt_q, s_gt_d;
  logic             s_lt_q, s_lt_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;

  logic             d_gt, d_lt;
  logic             nxt_gt, nxt_lt;
  logic             last_step;
  logic             finish;

  digit_compare #(
    .DIGIT (DIGIT)
  ) u_digit_compare (
    .x  (sa_q[WIDTH-1 -: DIGIT]),
    .y  (sb_q[WIDTH-1 -: DIGIT]),
    .gt (d_gt),
    .lt (d_lt)
  );

  // Once either sticky flag is set the decision is made; later digits are
  // less significant and must not override it.
  assign nxt_gt = (s_gt_q | s_lt_q) ? s_gt_q : d_gt;
  assign nxt_lt = (s_gt_q | s_lt_q) ? s_lt_q : d_lt;

  assign last_step = (cnt_q == CW'(NSTEP - 1));

`ifdef EARLY_EXIT_EN
  assign finish = last_step | nxt_gt | nxt_lt;
`else
  assign finish = last_step;
`endif

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    s_gt_d  = s_gt_q;
    s_lt_d  = s_lt_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CMP;
          sa_d    = a;
          sb_d    = b;
          cnt_d   = '0;
          s_gt_d  = 1'b0;
          s_lt_d  = 1'b0;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          eq_d    = 1'b0;
        end
      end

      CMP: begin
        s_gt_d = nxt_gt;
        s_lt_d = nxt_lt;
        sa_d   = sa_q << DIGIT;
        sb_d   = sb_q << DIGIT;
        cnt_d  = cnt_q + CW'(1);
        if (finish) begin
          // Result is loaded on the same edge that enters DONE so it is
          // already visible while done is high.
          state_d = DONE;
          gt_d    = nxt_gt;
          lt_d    = nxt_lt;
          eq_d    = ~(nxt_gt | nxt_lt);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      s_gt_q  <= 1'b0;
      s_lt_q  <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      s_gt_q  <= s_gt_d;
      s_lt_q  <= s_lt_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign busy  = (state_q == CMP);
  assign done  = (state_q == DONE);
  assign gt    = gt_q;
  assign lt    = lt_q;
  assign eq    = eq_q;

endmodule

// File: tb/tb_serial_magnitude_compare.sv
// tb/tb_serial_magnitude_compare.sv - directed self-checking bench for serial_magnitude_compare

module tb_serial_magnitude_compare;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       ready;
  logic       busy;
  logic       done;
  logic       gt;
  logic       lt;
  logic       eq;

  int n_tests;
  int n_fail;

`ifdef EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  serial_magnitude_compare #(
    .WIDTH (8),
    .DIGIT (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .gt    (gt),
    .lt    (lt),
    .eq    (eq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_idle_clear(input string tag);
    check({tag, " ready"}, int'(ready), 1);
    check({tag, " busy"},  int'(busy),  0);
    check({tag, " done"},  int'(done),  0);
    check({tag, " gt"},    int'(gt),    0);
    check({tag, " lt"},    int'(lt),    0);
    check({tag, " eq"},    int'(eq),    0);
  endtask

  // Latency counts rising edges from the accepting edge (inclusive) up to the
  // edge after which done is first seen high.
  task automatic run_cmp(input string tag, input logic [7:0] va, input logic [7:0] vb,
                         input bit egt, input bit elt, input int elat, input bit inject);
    int n;
    @(negedge clk);
    check({tag, " ready before start"}, int'(ready), 1);
    start = 1'b1;
    a     = va;
    b     = vb;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, " busy after accept"}, int'(busy), 1);
    check({tag, " cleared gt"}, int'(gt), 0);
    check({tag, " cleared lt"}, int'(lt), 0);
    check({tag, " cleared eq"}, int'(eq), 0);
    if (inject) begin
      start = 1'b1;
      a     = 8'h00;
      b     = 8'hFF;
    end else begin
      a = ~va;
      b = ~vb;
    end
    n = 1;
    while (!done && n < 10) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
    end
    check({tag, " done"}, int'(done), 1);
    check({tag, " latency"}, n, elat);
    check({tag, " gt"}, int'(gt), int'(egt));
    check({tag, " lt"}, int'(lt), int'(elt));
    check({tag, " eq"}, int'(eq), int'(!(egt || elt)));
    @(posedge clk);
    #1;
    check({tag, " done one cycle"}, int'(done), 0);
    check({tag, " ready after"}, int'(ready), 1);
    check({tag, " gt held"}, int'(gt), int'(egt));
    check({tag, " lt held"}, int'(lt), int'(elt));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    start   = 1'b0;
    a       = 8'h00;
    b       = 8'h00;
    rst_n   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_clear("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_idle_clear("idle after reset");

    run_cmp("5A>3F", 8'h5A, 8'h3F, 1'b1, 1'b0, EE ? 2 : 3, 1'b0);
    run_cmp("37<39", 8'h37, 8'h39, 1'b0, 1'b1, 3, 1'b0);
    run_cmp("C3==C3", 8'hC3, 8'hC3, 1'b0, 1'b0, 3, 1'b0);

    // Start pulsed with 00/FF while busy must be ignored.
    run_cmp("busy ignore", 8'h5A, 8'h3F, 1'b1, 1'b0, EE ? 2 : 3, 1'b1);
    run_cmp("00<FF", 8'h00, 8'hFF, 1'b0, 1'b1, EE ? 2 : 3, 1'b0);

    // Back-to-back: second start lands in the first IDLE cycle after DONE.
    run_cmp("FF>00", 8'hFF, 8'h00, 1'b1, 1'b0, EE ? 2 : 3, 1'b0);
    run_cmp("10>01", 8'h10, 8'h01, 1'b1, 1'b0, EE ? 2 : 3, 1'b0);

    // Boundary: difference only in the last digit.
    run_cmp("A1>A0", 8'hA1, 8'hA0, 1'b1, 1'b0, 3, 1'b0);

    // Reset mid-CMP: outputs return to reset values at once, no done pulse.
    @(negedge clk);
    start = 1'b1;
    a     = 8'h37;
    b     = 8'h39;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("midreset busy before", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_clear("midreset");
    repeat (3) begin
      @(posedge clk);
      #1;
      check("midreset no done", int'(done), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("after midreset no done", int'(done), 0);
    end
    check_idle_clear("after midreset");

    run_cmp("post reset 39>37", 8'h39, 8'h37, 1'b1, 1'b0, 3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
